flash_cmd_seq: RTL and testbench

// Sequences JEDEC command cycles to the on-board 8-bit boot flash so software can program/erase it

---
 rtl/flash_cmd_seq_pkg.sv | 72 +++++++
 rtl/flash_bus_cycle.sv | 107 ++++++++++
 rtl/flash_cmd_seq.sv | 176 +++++++++++++++++
 tb/tb_flash_cmd_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_cmd_seq_pkg.sv
// Shared encodings for the boot-flash command sequencer: command ops, JEDEC unlock
// addresses/bytes, FSM state codes and the per-command write-list lookup.
package flash_cmd_seq_pkg;

  localparam logic [1:0] OP_PROG = 2'b00;
  localparam logic [1:0] OP_SECT = 2'b01;
  localparam logic [1:0] OP_CHIP = 2'b10;
  localparam logic [1:0] OP_RST  = 2'b11;

  localparam logic [10:0] ULK_A1 = 11'h555;
  localparam logic [10:0] ULK_A2 = 11'h2AA;

  localparam logic [7:0] B_AA = 8'hAA;
  localparam logic [7:0] B_55 = 8'h55;
  localparam logic [7:0] B_A0 = 8'hA0;
  localparam logic [7:0] B_80 = 8'h80;
  localparam logic [7:0] B_30 = 8'h30;
  localparam logic [7:0] B_10 = 8'h10;
  localparam logic [7:0] B_F0 = 8'hF0;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_POLL   = 3'd2;
  localparam logic [2:0] S_RST_F0 = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [2:0] BUS_IDLE = 3'd0;
  localparam logic [2:0] WR_SETUP = 3'd1;
  localparam logic [2:0] WR_LOW   = 3'd2;
  localparam logic [2:0] WR_HOLD  = 3'd3;
  localparam logic [2:0] WR_GAP   = 3'd4;
  localparam logic [2:0] POLL_RD  = 3'd5;
  localparam logic [2:0] POLL_CHK = 3'd6;

  typedef struct packed {
    logic        use_cmd_addr;
    logic [10:0] ulk_addr;
    logic [7:0]  data;
  } wr_ent_t;

  function automatic logic [2:0] last_idx(input logic [1:0] op);
    case (op)
      OP_PROG: return 3'd3;
      OP_RST:  return 3'd0;
      default: return 3'd5;
    endcase
  endfunction

  // Entry idx of the bus-write list for op; erase lists share their first five cycles.
  function automatic wr_ent_t wr_entry(input logic [1:0] op, input logic [2:0] idx,
                                       input logic [7:0] data);
    wr_ent_t e;
    e = '{use_cmd_addr: 1'b0, ulk_addr: ULK_A1, data: B_AA};
    if (op == OP_RST) begin
      e.ulk_addr = '0;
      e.data     = B_F0;
    end else begin
      case (idx)
        3'd0: e.data = B_AA;
        3'd1, 3'd4: begin e.ulk_addr = ULK_A2; e.data = B_55; end
        3'd2: e.data = (op == OP_PROG) ? B_A0 : B_80;
        3'd3: if (op == OP_PROG) begin e.use_cmd_addr = 1'b1; e.data = data; end
        default: begin
          if (op == OP_CHIP) e.data = B_10;
          else begin e.use_cmd_addr = 1'b1; e.data = B_30; end
        end
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// One flash bus strobe: a write (setup, WE low, hold, gap) or a poll read (OE low, check).
// A new start is taken while idle or in the final cycle so strobes can run back to back.
module flash_bus_cycle
  import flash_cmd_seq_pkg::*;
#(
  parameter int ADDR_W   = 19,
  parameter int WE_PULSE = 2,
  parameter int OE_PULSE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              idle,
  output logic              done,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] flash_a,
  output logic [7:0]        flash_dout,
  output logic              flash_doe,
  output logic              flash_ce_n,
  output logic              flash_we_n,
  output logic              flash_oe_n,
  input  logic [7:0]        flash_din
);

  localparam int MAXP = (WE_PULSE > OE_PULSE) ? WE_PULSE : OE_PULSE;
  localparam int CW   = (MAXP < 2) ? 1 : $clog2(MAXP + 1);

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [7:0]        dout_q, dout_d, rdata_q, rdata_d;
  logic              doe_q, doe_d, ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;

  assign idle = (state_q == BUS_IDLE);
  assign done = (state_q == WR_GAP) || (state_q == POLL_CHK);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    case (state_q)
      WR_SETUP: begin state_d = WR_LOW; cnt_d = CW'(WE_PULSE - 1); end
      WR_LOW:   if (cnt_q == '0) state_d = WR_HOLD; else cnt_d = cnt_q - CW'(1);
      WR_HOLD:  state_d = WR_GAP;
      POLL_RD: begin
        if (cnt_q == '0) begin
          rdata_d = flash_din;
          state_d = POLL_CHK;
        end else cnt_d = cnt_q - CW'(1);
      end
      default:  state_d = BUS_IDLE;
    endcase
    if (start && (idle || done)) begin
      a_d = addr;
      if (rd) begin
        state_d = POLL_RD;
        cnt_d   = CW'(OE_PULSE - 1);
      end else begin
        state_d = WR_SETUP;
        dout_d  = wdata;
      end
    end
    // Strobes are registered from the next state so they never glitch.
    doe_d  = (state_d == WR_SETUP) || (state_d == WR_LOW) || (state_d == WR_HOLD);
    ce_n_d = !(doe_d || (state_d == POLL_RD));
    we_n_d = (state_d != WR_LOW);
    oe_n_d = (state_d != POLL_RD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUS_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      doe_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      doe_q   <= doe_d;
      ce_n_q  <= ce_n_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
    end
  end

  assign rdata      = rdata_q;
  assign flash_a    = a_q;
  assign flash_dout = dout_q;
  assign flash_doe  = doe_q;
  assign flash_ce_n = ce_n_q;
  assign flash_we_n = we_n_q;
  assign flash_oe_n = oe_n_q;

endmodule

// File: rtl/flash_cmd_seq.sv
// Boot-flash command sequencer: walks the JEDEC write list for one command, polls DQ7/DQ5
// for completion and recovers from failures with a read-reset.
//   state    | meaning
//   IDLE     | ready for a command
//   WRITE    | issuing the unlock/command write list
//   POLL     | reading status until pass, DQ5 failure or poll limit
//   RST_F0   | read-reset write (error recovery or read-reset op)
//   DONE     | one cycle before returning to IDLE
module flash_cmd_seq
  import flash_cmd_seq_pkg::*;
#(
  parameter int          ADDR_W     = 19,
  parameter int          WE_PULSE   = 2,
  parameter int          OE_PULSE   = 2,
  parameter logic [23:0] POLL_LIMIT = 24'hFFFFFF
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_data,
  output logic              cmd_ready,
  output logic [ADDR_W-1:0] FLASH_A,
  output logic [7:0]        FLASH_DOUT,
  output logic              FLASH_DOE,
  input  logic [7:0]        FLASH_DIN,
  output logic              FLASH_CE_n,
  output logic              FLASH_WE_n,
  output logic              FLASH_OE_n,
  output logic              FLASH_BUSY_n,
  output logic              err,
  input  logic              err_clr
);

  logic [2:0]        state_q, state_d, idx_q, idx_d, ent_idx;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d, bus_addr;
  logic [7:0]        data_q, data_d, bus_data, bus_rdata;
  logic [23:0]       cnt_q, cnt_d, cnt_nxt;
  logic              retry_q, retry_d, err_q, err_d, busy_n_q, busy_n_d, ready_q, ready_d;
  logic              err_set, bus_start, bus_rd, use_f0, poll_pass, bus_idle, bus_done;
  wr_ent_t           ent;
  logic              unused_rdata;

  assign unused_rdata = ^{bus_rdata[6], bus_rdata[4:0]};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    err_set   = 1'b0;
    bus_start = 1'b0;
    bus_rd    = 1'b0;
    use_f0    = 1'b0;
    ent_idx   = idx_q;
    poll_pass = (op_q == OP_PROG) ? (bus_rdata[7] == data_q[7]) : bus_rdata[7];
    cnt_nxt   = cnt_q + 24'd1;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          data_d  = cmd_data;
          idx_d   = '0;
          cnt_d   = '0;
          retry_d = 1'b0;
          state_d = (cmd_op == OP_RST) ? S_RST_F0 : S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus_idle) bus_start = 1'b1;
        else if (bus_done) begin
          bus_start = 1'b1;
          if (idx_q == last_idx(op_q)) begin
            bus_rd  = 1'b1;
            state_d = S_POLL;
          end else begin
            ent_idx = idx_q + 3'd1;
            idx_d   = ent_idx;
          end
        end
      end
      S_POLL: begin
        if (bus_done) begin
          cnt_d = cnt_nxt;
          if (poll_pass) state_d = S_DONE;
          else if (retry_q || (cnt_nxt >= POLL_LIMIT)) begin
            err_set   = 1'b1;
            use_f0    = 1'b1;
            bus_start = 1'b1;
            state_d   = S_RST_F0;
          end else begin
            // DQ5 high on a failed sample earns exactly one confirming re-read.
            retry_d   = bus_rdata[5];
            bus_start = 1'b1;
            bus_rd    = 1'b1;
          end
        end
      end
      S_RST_F0: begin
        use_f0 = 1'b1;
        if (bus_idle) bus_start = 1'b1;
        else if (bus_done) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    err_d    = err_set || (err_q && !err_clr);
    busy_n_d = (state_d == S_IDLE);
    ready_d  = (state_d == S_IDLE);
  end

  assign ent      = wr_entry(op_q, ent_idx, data_q);
  assign bus_addr = bus_rd           ? ((op_q == OP_CHIP) ? '0 : addr_q) :
                    use_f0           ? '0 :
                    ent.use_cmd_addr ? addr_q : ADDR_W'(ent.ulk_addr);
  assign bus_data = use_f0 ? B_F0 : ent.data;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      retry_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_n_q <= 1'b1;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      err_q    <= err_d;
      busy_n_q <= busy_n_d;
      ready_q  <= ready_d;
    end
  end

  assign cmd_ready    = ready_q;
  assign FLASH_BUSY_n = busy_n_q;
  assign err          = err_q;

  flash_bus_cycle #(
    .ADDR_W  (ADDR_W),
    .WE_PULSE(WE_PULSE),
    .OE_PULSE(OE_PULSE)
  ) u_bus (
    .clk       (CLK),
    .rst_n     (RESET_n),
    .start     (bus_start),
    .rd        (bus_rd),
    .addr      (bus_addr),
    .wdata     (bus_data),
    .idle      (bus_idle),
    .done      (bus_done),
    .rdata     (bus_rdata),
    .flash_a   (FLASH_A),
    .flash_dout(FLASH_DOUT),
    .flash_doe (FLASH_DOE),
    .flash_ce_n(FLASH_CE_n),
    .flash_we_n(FLASH_WE_n),
    .flash_oe_n(FLASH_OE_n),
    .flash_din (FLASH_DIN)
  );

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Bench for flash_cmd_seq: a small flash model, a write/read monitor, a command vector table
// and directed sequences for error, abort and poll-limit corners.
module tb_flash_cmd_seq;
  import flash_cmd_seq_pkg::*;

  localparam int AW  = 19;
  localparam int WEP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, err_clr = 1'b0;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_data = '0;
  logic          cmd_ready, doe, ce_n, we_n, oe_n, busy_n, err;
  logic [AW-1:0] fa;
  logic [7:0]    fdout, fdin;

  logic          l_cmd_valid = 1'b0, l_err_clr = 1'b0;
  logic [1:0]    l_cmd_op = '0;
  logic [AW-1:0] l_cmd_addr = '0;
  logic [7:0]    l_cmd_data = '0;
  logic          l_cmd_ready, l_doe, l_ce_n, l_we_n, l_oe_n, l_busy_n, l_err;
  logic [AW-1:0] l_fa;
  logic [7:0]    l_fdout;

  flash_cmd_seq #(.ADDR_W(AW), .WE_PULSE(WEP), .OE_PULSE(2), .POLL_LIMIT(24'hFFFFFF)) dut (
    .CLK(clk), .RESET_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .FLASH_A(fa), .FLASH_DOUT(fdout),
    .FLASH_DOE(doe), .FLASH_DIN(fdin), .FLASH_CE_n(ce_n), .FLASH_WE_n(we_n),
    .FLASH_OE_n(oe_n), .FLASH_BUSY_n(busy_n), .err(err), .err_clr(err_clr));

  flash_cmd_seq #(.ADDR_W(AW), .WE_PULSE(WEP), .OE_PULSE(2), .POLL_LIMIT(24'd8)) dut_lim (
    .CLK(clk), .RESET_n(rst_n), .cmd_valid(l_cmd_valid), .cmd_op(l_cmd_op),
    .cmd_addr(l_cmd_addr), .cmd_data(l_cmd_data), .cmd_ready(l_cmd_ready), .FLASH_A(l_fa),
    .FLASH_DOUT(l_fdout), .FLASH_DOE(l_doe), .FLASH_DIN(8'h00), .FLASH_CE_n(l_ce_n),
    .FLASH_WE_n(l_we_n), .FLASH_OE_n(l_oe_n), .FLASH_BUSY_n(l_busy_n), .err(l_err),
    .err_clr(l_err_clr));

  int checks = 0;
  int errors = 0;

  // Flash model: reads 1..busy_polls of the current command return busy_byte.
  int         busy_polls = 0, rd_base = 0, rd_cnt = 0;
  logic [7:0] busy_byte = 8'h00, ready_byte = 8'h00;
  assign fdin = ((rd_cnt - rd_base) <= busy_polls) ? busy_byte : ready_byte;

  logic [AW-1:0] wa[$];
  logic [7:0]    wd[$];
  int            we_low = 0, we_bad = 0;
  logic          we_prev = 1'b1, oe_prev = 1'b1;
  logic [AW-1:0] rd_a = '0;

  always @(negedge clk) begin
    if (!we_n) we_low++;
    else if (!we_prev) begin
      wa.push_back(fa);
      wd.push_back(fdout);
      if (we_low != WEP) we_bad++;
      we_low = 0;
    end
    if (oe_prev && !oe_n) begin
      rd_cnt++;
      rd_a = fa;
    end
    we_prev = we_n;
    oe_prev = oe_n;
  end

  int            l_wr_cnt = 0, l_rd_cnt = 0;
  logic          l_we_prev = 1'b1, l_oe_prev = 1'b1;
  logic [AW-1:0] l_last_a = '0;
  logic [7:0]    l_last_d = '0;

  always @(negedge clk) begin
    if (l_we_n && !l_we_prev) begin
      l_wr_cnt++;
      l_last_a = l_fa;
      l_last_d = l_fdout;
    end
    if (l_oe_prev && !l_oe_n) l_rd_cnt++;
    l_we_prev = l_we_n;
    l_oe_prev = l_oe_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void exp_wr(input logic [1:0] op, input int i, input logic [AW-1:0] a,
                                 input logic [7:0] d, output logic [AW-1:0] ea,
                                 output logic [7:0] ed);
    ea = '0;
    ed = 8'hF0;
    if (op == OP_PROG) begin
      case (i)
        0: begin ea = 19'h00555; ed = 8'hAA; end
        1: begin ea = 19'h002AA; ed = 8'h55; end
        2: begin ea = 19'h00555; ed = 8'hA0; end
        3: begin ea = a;         ed = d;     end
        default: ;
      endcase
    end else if (op != OP_RST) begin
      case (i)
        0, 3: begin ea = 19'h00555; ed = 8'hAA; end
        1, 4: begin ea = 19'h002AA; ed = 8'h55; end
        2: begin ea = 19'h00555; ed = 8'h80; end
        5: begin
          if (op == OP_CHIP) begin ea = 19'h00555; ed = 8'h10; end
          else begin ea = a; ed = 8'h30; end
        end
        default: ;
      endcase
    end
  endfunction

  task automatic set_model(input int busy, input logic [7:0] bb, input logic [7:0] rb);
    busy_polls = busy;
    busy_byte  = bb;
    ready_byte = rb;
    rd_base    = rd_cnt;
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("accept_busy_n", 32'(busy_n), 32'd0);
    chk("accept_ready", 32'(cmd_ready), 32'd0);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000 && !busy_n; k++) @(negedge clk);
    chk("done_timeout_busy_n", 32'(busy_n), 32'd1);
  endtask

  task automatic check_writes(input string tag, input int w0, input logic [1:0] op,
                              input logic [AW-1:0] a, input logic [7:0] d, input int nwr);
    logic [AW-1:0] ea;
    logic [7:0]    ed;
    chk({tag, "_nwrites"}, 32'(wa.size() - w0), 32'(nwr));
    for (int i = 0; i < nwr && (w0 + i) < wa.size(); i++) begin
      exp_wr(op, i, a, d, ea, ed);
      chk($sformatf("%s_wr%0d_addr", tag, i), 32'(wa[w0 + i]), 32'(ea));
      chk($sformatf("%s_wr%0d_data", tag, i), 32'(wd[w0 + i]), 32'(ed));
    end
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            busy;
    logic [7:0]    bbyte;
    logic [7:0]    rbyte;
    int            nwr;
    int            nrd;
    logic [AW-1:0] rd_addr;
    logic          exp_err;
  } vec_t;

  initial begin
    vec_t v[6];
    int   w0, b0, lw0, lr0, k;

    v[0] = '{OP_PROG, 19'h01234, 8'h5A, 10,  8'h80, 8'h5A, 4, 11, 19'h01234, 1'b0};
    v[1] = '{OP_SECT, 19'h10000, 8'h00, 0,   8'h00, 8'h80, 6, 1,  19'h10000, 1'b0};
    v[2] = '{OP_CHIP, 19'h12345, 8'h00, 3,   8'h00, 8'h80, 6, 4,  19'h00000, 1'b0};
    v[3] = '{OP_RST,  19'h00000, 8'h00, 0,   8'h00, 8'h00, 1, 0,  19'h00000, 1'b0};
    v[4] = '{OP_PROG, 19'h01234, 8'h5A, 100, 8'hA0, 8'h5A, 5, 2,  19'h01234, 1'b1};
    v[5] = '{OP_PROG, 19'h00777, 8'hC3, 2,   8'h00, 8'hC3, 4, 3,  19'h00777, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_ce_n", 32'(ce_n), 32'd1);
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_oe_n", 32'(oe_n), 32'd1);
    chk("rst_doe", 32'(doe), 32'd0);
    chk("rst_addr", 32'(fa), 32'd0);
    chk("rst_dout", 32'(fdout), 32'd0);
    chk("rst_busy_n", 32'(busy_n), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      w0 = wa.size();
      b0 = we_bad;
      set_model(v[i].busy, v[i].bbyte, v[i].rbyte);
      start_cmd(v[i].op, v[i].addr, v[i].data);
      wait_done();
      check_writes($sformatf("vec%0d", i), w0, v[i].op, v[i].addr, v[i].data, v[i].nwr);
      chk($sformatf("vec%0d_we_pulse", i), 32'(we_bad - b0), 32'd0);
      chk($sformatf("vec%0d_nreads", i), 32'(rd_cnt - rd_base), 32'(v[i].nrd));
      if (v[i].nrd > 0) chk($sformatf("vec%0d_poll_addr", i), 32'(rd_a), 32'(v[i].rd_addr));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(v[i].exp_err));
      chk($sformatf("vec%0d_ready", i), 32'(cmd_ready), 32'd1);
    end

    // err_clr clears the sticky flag but loses to a new error in the same cycle.
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("err_clr_alone", 32'(err), 32'd0);
    w0 = wa.size();
    set_model(100, 8'hA0, 8'h5A);
    start_cmd(OP_PROG, 19'h01234, 8'h5A);
    for (k = 0; k < 500 && !((rd_cnt - rd_base) == 2 && oe_n); k++) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    wait_done();
    chk("err_clr_vs_set", 32'(err), 32'd1);
    check_writes("clr_race", w0, OP_PROG, 19'h01234, 8'h5A, 5);

    // A strobe during an erase is dropped, never queued.
    w0 = wa.size();
    set_model(5, 8'h00, 8'h80);
    start_cmd(OP_SECT, 19'h10000, 8'h00);
    repeat (8) @(negedge clk);
    cmd_op    = OP_PROG;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done();
    check_writes("mid_erase", w0, OP_SECT, 19'h10000, 8'h00, 6);
    repeat (20) @(negedge clk);
    chk("mid_erase_no_extra", 32'(wa.size() - w0), 32'd6);
    chk("mid_erase_idle_busy_n", 32'(busy_n), 32'd1);

    // Poll limit of 8 on the second instance, status never passes.
    lw0 = l_wr_cnt;
    lr0 = l_rd_cnt;
    @(negedge clk);
    l_cmd_op    = OP_SECT;
    l_cmd_addr  = 19'h20000;
    l_cmd_valid = 1'b1;
    @(negedge clk);
    l_cmd_valid = 1'b0;
    for (k = 0; k < 3000 && !l_busy_n; k++) @(negedge clk);
    chk("lim_done_busy_n", 32'(l_busy_n), 32'd1);
    chk("lim_nreads", 32'(l_rd_cnt - lr0), 32'd8);
    chk("lim_err", 32'(l_err), 32'd1);
    chk("lim_nwrites", 32'(l_wr_cnt - lw0), 32'd7);
    chk("lim_f0_addr", 32'(l_last_a), 32'd0);
    chk("lim_f0_data", 32'(l_last_d), 32'hF0);
    chk("lim_ready", 32'(l_cmd_ready), 32'd1);

    // Asynchronous reset in the middle of a WE pulse.
    set_model(0, 8'h00, 8'h5A);
    start_cmd(OP_PROG, 19'h00100, 8'h5A);
    for (k = 0; k < 50 && we_n; k++) @(negedge clk);
    chk("pre_reset_we_low", 32'(we_n), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_we_n", 32'(we_n), 32'd1);
    chk("arst_ce_n", 32'(ce_n), 32'd1);
    chk("arst_oe_n", 32'(oe_n), 32'd1);
    chk("arst_busy_n", 32'(busy_n), 32'd1);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    chk("arst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w0 = wa.size();
    repeat (30) @(negedge clk);
    chk("arst_no_f0", 32'(wa.size() - w0), 32'd0);
    chk("arst_idle_busy_n", 32'(busy_n), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
